// File: rtl/sao_stat_ctb_accum.sv
// Per-CTB accumulator for SAO statistics: sums matched diffs and counts over one CTB,
// then presents saturating sum/count plus a sticky saturation flag with a one-cycle valid.
module sao_stat_ctb_accum #(
   parameter int unsigned diff_clip_bit = 4,
   parameter int unsigned PIX6          = 6,
   parameter int unsigned SUM_W         = 18,
   parameter int unsigned CNT_W         = 13
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             isWorking_stat,
   input  logic                             en,
   input  logic                             ctb_start,
   input  logic                             ctb_last,
   input  logic signed [diff_clip_bit+3:0]  s61,
   input  logic [$clog2(PIX6+1)-1:0]        cnt_in,
   output logic signed [SUM_W-1:0]          sum_o,
   output logic [CNT_W-1:0]                 num_o,
   output logic                             sat_o,
   output logic                             out_valid,
   output logic                             busy
);

   localparam int unsigned S_W = diff_clip_bit + 4;
   localparam int unsigned C_W = $clog2(PIX6 + 1);

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e                  state_q, state_d;
   logic signed [SUM_W-1:0] acc_sum_q, acc_sum_d;
   logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
   logic                    sat_q, sat_d;

   logic                    acc, take, finish;
   logic signed [SUM_W-1:0] base_sum, sum_sat;
   logic [CNT_W-1:0]        base_cnt, cnt_sat;
   logic                    base_sat, sum_ovf, cnt_ovf;
   logic signed [SUM_W:0]   sum_wide;
   logic [CNT_W:0]          cnt_wide;

   always_comb begin
      acc    = en & isWorking_stat;
      // Beats count only once a CTB is open, or when this beat opens one.
      take   = acc & (ctb_start | (state_q == StAcc));
      finish = take & ctb_last;

      base_sum = ctb_start ? '0 : acc_sum_q;
      base_cnt = ctb_start ? '0 : acc_cnt_q;
      base_sat = ctb_start ? 1'b0 : sat_q;

      sum_wide = $signed({base_sum[SUM_W-1], base_sum})
               + $signed({{(SUM_W + 1 - S_W){s61[S_W-1]}}, s61});
      sum_ovf  = sum_wide[SUM_W] != sum_wide[SUM_W-1];
      if (!sum_ovf) begin
         sum_sat = sum_wide[SUM_W-1:0];
      end else if (sum_wide[SUM_W]) begin
         sum_sat = {1'b1, {(SUM_W - 1){1'b0}}};
      end else begin
         sum_sat = {1'b0, {(SUM_W - 1){1'b1}}};
      end

      cnt_wide = {1'b0, base_cnt} + {{(CNT_W + 1 - C_W){1'b0}}, cnt_in};
      cnt_ovf  = cnt_wide[CNT_W];
      cnt_sat  = cnt_ovf ? {CNT_W{1'b1}} : cnt_wide[CNT_W-1:0];

      acc_sum_d = take ? sum_sat : base_sum;
      acc_cnt_d = take ? cnt_sat : base_cnt;
      sat_d     = take ? (base_sat | sum_ovf | cnt_ovf) : base_sat;

      if (finish) begin
         state_d = StDone;
      end else if (ctb_start || (state_q == StAcc)) begin
         state_d = StAcc;
      end else begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         acc_sum_q <= '0;
         acc_cnt_q <= '0;
         sat_q     <= 1'b0;
         sum_o     <= '0;
         num_o     <= '0;
         sat_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_sum_q <= acc_sum_d;
         acc_cnt_q <= acc_cnt_d;
         sat_q     <= sat_d;
         if (finish) begin
            sum_o <= acc_sum_d;
            num_o <= acc_cnt_d;
            sat_o <= sat_d;
         end
      end
   end

   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StAcc);

endmodule

// File: tb/tb_sao_stat_ctb_accum.sv
// Directed bench for sao_stat_ctb_accum: default build plus a narrow build for saturation.
module tb_sao_stat_ctb_accum;

   logic              clk = 1'b0;
   logic              rst, isWorking_stat, en, ctb_start, ctb_last;
   logic signed [7:0] s61;
   logic [2:0]        cnt_in;

   logic signed [17:0] sum_o;
   logic [12:0]        num_o;
   logic               sat_o, out_valid, busy;

   logic signed [7:0]  sum2;
   logic [3:0]         num2;
   logic               sat2, valid2, busy2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sao_stat_ctb_accum dut (
      .clk(clk), .rst(rst), .isWorking_stat(isWorking_stat), .en(en),
      .ctb_start(ctb_start), .ctb_last(ctb_last), .s61(s61), .cnt_in(cnt_in),
      .sum_o(sum_o), .num_o(num_o), .sat_o(sat_o), .out_valid(out_valid), .busy(busy)
   );

   sao_stat_ctb_accum #(.SUM_W(8), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .isWorking_stat(isWorking_stat), .en(en),
      .ctb_start(ctb_start), .ctb_last(ctb_last), .s61(s61), .cnt_in(cnt_in),
      .sum_o(sum2), .num_o(num2), .sat_o(sat2), .out_valid(valid2), .busy(busy2)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one set of inputs across a rising edge, then let outputs settle.
   task automatic beat(input logic st, input logic e, input logic ws, input logic last,
                       input int s, input int c);
      ctb_start      = st;
      en             = e;
      isWorking_stat = ws;
      ctb_last       = last;
      s61            = 8'(s);
      cnt_in         = 3'(c);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      beat(0, 0, 0, 0, 0, 0);
      beat(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      check("reset_sum", $signed(sum_o), 0);
      check("reset_num", num_o, 0);
      check("reset_sat", sat_o, 0);
      check("reset_valid", out_valid, 0);
      check("reset_busy", busy, 0);

      // Basic CTB
      beat(1, 1, 1, 0, 5, 2);
      check("basic_busy1", busy, 1);
      check("basic_valid1", out_valid, 0);
      beat(0, 1, 1, 0, -3, 1);
      check("basic_busy2", busy, 1);
      beat(0, 1, 1, 1, 7, 6);
      check("basic_valid", out_valid, 1);
      check("basic_sum", $signed(sum_o), 9);
      check("basic_num", num_o, 9);
      check("basic_sat", sat_o, 0);
      check("basic_busy_done", busy, 0);
      beat(0, 0, 1, 0, 0, 0);
      check("basic_valid_drop", out_valid, 0);
      check("basic_hold_sum", $signed(sum_o), 9);

      // Gating: a beat in IDLE without ctb_start is ignored
      beat(0, 1, 1, 1, 4, 1);
      check("idle_ignore_busy", busy, 0);
      check("idle_ignore_valid", out_valid, 0);
      beat(1, 1, 1, 0, 1, 1);
      beat(0, 0, 1, 1, 4, 1);
      check("gate_en_last_valid", out_valid, 0);
      check("gate_en_last_busy", busy, 1);
      beat(0, 1, 0, 1, 4, 1);
      check("gate_ws_valid", out_valid, 0);
      beat(0, 1, 1, 0, 1, 1);
      beat(0, 1, 1, 1, 1, 1);
      check("gate_valid", out_valid, 1);
      check("gate_sum", $signed(sum_o), 3);
      check("gate_num", num_o, 3);
      beat(0, 0, 1, 0, 0, 0);

      // Single-beat CTB
      beat(1, 1, 1, 1, -8, 6);
      check("single_valid", out_valid, 1);
      check("single_sum", $signed(sum_o), -8);
      check("single_num", num_o, 6);
      check("single_busy", busy, 0);
      beat(0, 0, 1, 0, 0, 0);

      // Abort and restart
      beat(1, 1, 1, 0, 10, 1);
      beat(0, 1, 1, 0, 10, 1);
      check("abort_valid1", out_valid, 0);
      beat(1, 1, 1, 0, 2, 1);
      check("abort_valid2", out_valid, 0);
      check("abort_busy", busy, 1);
      beat(0, 1, 1, 1, 3, 2);
      check("abort_valid", out_valid, 1);
      check("abort_sum", $signed(sum_o), 5);
      check("abort_num", num_o, 3);
      beat(0, 0, 1, 0, 0, 0);
      check("abort_single_pulse", out_valid, 0);

      // Back-to-back CTBs with ctb_start in the DONE cycle
      beat(1, 1, 1, 0, 1, 1);
      beat(0, 1, 1, 1, 2, 1);
      check("b2b_valid1", out_valid, 1);
      check("b2b_sum1", $signed(sum_o), 3);
      check("b2b_num1", num_o, 2);
      beat(1, 1, 1, 0, 4, 3);
      check("b2b_busy", busy, 1);
      check("b2b_valid_gap", out_valid, 0);
      check("b2b_hold_sum", $signed(sum_o), 3);
      beat(0, 1, 1, 1, 5, 2);
      check("b2b_valid2", out_valid, 1);
      check("b2b_sum2", $signed(sum_o), 9);
      check("b2b_num2", num_o, 5);
      beat(0, 0, 1, 0, 0, 0);

      // Saturation on the narrow build (SUM_W=8, CNT_W=4)
      beat(1, 1, 1, 0, 60, 6);
      beat(0, 1, 1, 0, 60, 6);
      beat(0, 1, 1, 1, 60, 6);
      check("sat_valid", valid2, 1);
      check("sat_sum", $signed(sum2), 127);
      check("sat_num", num2, 15);
      check("sat_flag", sat2, 1);
      check("wide_nosat_sum", $signed(sum_o), 180);
      check("wide_nosat_flag", sat_o, 0);
      beat(0, 0, 1, 0, 0, 0);
      beat(1, 1, 1, 0, -100, 0);
      beat(0, 1, 1, 1, -100, 0);
      check("negsat_sum", $signed(sum2), -128);
      check("negsat_flag", sat2, 1);
      beat(1, 1, 1, 1, 1, 1);
      check("sat_clear_flag", sat2, 0);
      check("sat_clear_sum", $signed(sum2), 1);
      beat(0, 0, 1, 0, 0, 0);

      // Reset mid-CTB
      beat(1, 1, 1, 0, 3, 1);
      rst = 1'b1;
      beat(0, 1, 1, 1, 3, 1);
      rst = 1'b0;
      check("rst_sum", $signed(sum_o), 0);
      check("rst_num", num_o, 0);
      check("rst_sat", sat_o, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      beat(0, 1, 1, 1, 3, 1);
      check("rst_no_valid", out_valid, 0);
      check("rst_no_busy", busy, 0);
      beat(1, 1, 1, 0, 2, 2);
      beat(0, 1, 1, 1, 3, 2);
      check("rst_new_valid", out_valid, 1);
      check("rst_new_sum", $signed(sum_o), 5);
      check("rst_new_num", num_o, 4);
      beat(0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
